// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-bus request in flight,
// and hands {pc, raw_instr} to decode. Redirects squash wrong-path fetches.
module fetch_stage #(
  parameter logic [63:0] PC_INIT = 64'h0000_0000_8000_0000,
  parameter logic [63:0] PC_STEP = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer to decode happens in a cycle where out_valid && out_ready
  // and no redirect is present; the bus request holds ireq_valid/ireq_addr stable
  // until the cycle iresp_data_ok is seen.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_KILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_pend_pc;
  logic [31:0] r_instr_q;

  state_t      w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic [63:0] w_pend_pc_nxt;
  logic [31:0] w_instr_q_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_pc      <= PC_INIT;
      r_pend_pc <= 64'd0;
      r_instr_q <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_pc_nxt;
      r_instr_q <= w_instr_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_pc_nxt = r_pend_pc;
    w_instr_q_nxt = r_instr_q;
    case (r_state)
      ST_FETCH: begin
        if (redirect_valid && iresp_data_ok) begin
          w_pc_nxt = redirect_pc;
        end else if (redirect_valid) begin
          // The wrong-path request must still complete on the bus before we re-issue.
          w_pend_pc_nxt = redirect_pc;
          w_state_nxt   = ST_KILL;
        end else if (iresp_data_ok) begin
          w_instr_q_nxt = iresp_data;
          w_state_nxt   = ST_FULL;
        end
      end
      ST_KILL: begin
        if (redirect_valid) begin
          w_pend_pc_nxt = redirect_pc;
        end
        if (iresp_data_ok) begin
          w_pc_nxt    = redirect_valid ? redirect_pc : r_pend_pc;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FULL: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ST_FETCH;
        end else if (out_ready) begin
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  assign ireq_valid = !reset && ((r_state == ST_FETCH) || (r_state == ST_KILL));
  assign ireq_addr  = r_pc;
  assign out_valid  = !reset && (r_state == ST_FULL);
  assign out_pc     = r_pc;
  assign out_instr  = r_instr_q;
  assign dbg_state  = r_state;

endmodule
